// File: rtl/cache_req_queue_pkg.sv
// Shared types and default widths for the cache request queue.
package cache_req_pkg;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int DEPTH_DEF      = 4;
  localparam int TIMEOUT_DEF    = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } req_t;
endpackage

// File: rtl/cache_req_queue_if.sv
// Request, response and cache-side signals of the cache request queue.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// valid never waits on ready, and the offering side holds its payload until the transfer.
interface cache_req_queue_if #(
  parameter int ADDR_WIDTH = cache_req_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = cache_req_pkg::DATA_WIDTH_DEF,
  parameter int DEPTH      = cache_req_pkg::DEPTH_DEF
);
  import cache_req_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_hit;
  logic                  rsp_write;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  c_read;
  logic                  c_write;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_hit;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  c_strob;
  logic [CW-1:0]         count;
  state_t                dbg_state;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, c_hit, c_data, c_strob,
    output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_write, rsp_err,
           c_addr, c_read, c_write, c_wdata, count, dbg_state
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, c_hit, c_data, c_strob,
    input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_write, rsp_err,
           c_addr, c_read, c_write, c_wdata, count, dbg_state
  );
endinterface

// File: rtl/cache_req_queue_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and registered occupancy.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop) count_d = count_q + (PW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/cache_req_queue.sv
// Buffers processor requests, issues them to the cache one at a time and
// returns each result (or a timeout abort) on a valid/ready response port.
module cache_req_queue
  import cache_req_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  cache_req_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t        push_entry, head;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  c_read_q, c_read_d, c_write_q, c_write_d;
  logic [ADDR_WIDTH-1:0] c_addr_q, c_addr_d;
  logic [DATA_WIDTH-1:0] c_wdata_q, c_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic                  rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  assign bus.req_ready = rst && !fifo_full;
  assign fifo_push     = bus.req_valid && bus.req_ready;
  assign push_entry    = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

  sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    c_read_d    = c_read_q;
    c_write_d   = c_write_q;
    c_addr_d    = c_addr_q;
    c_wdata_d   = c_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Cache outputs are loaded here so they are registered and stable from ISSUE entry.
        if (!fifo_empty) begin
          state_d   = ISSUE;
          tmo_d     = '0;
          c_read_d  = !head.write;
          c_write_d = head.write;
          c_addr_d  = head.addr;
          c_wdata_d = head.wdata;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + TW'(1);
        if (bus.c_strob || tmo_q == TMO_LAST) begin
          state_d     = RESP;
          fifo_pop    = 1'b1;
          c_read_d    = 1'b0;
          c_write_d   = 1'b0;
          c_addr_d    = '0;
          c_wdata_d   = '0;
          rsp_valid_d = 1'b1;
          rsp_write_d = head.write;
          rsp_err_d   = !bus.c_strob;
          rsp_data_d  = bus.c_strob ? bus.c_data : '0;
          rsp_hit_d   = bus.c_strob ? bus.c_hit : 1'b0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      c_read_q    <= 1'b0;
      c_write_q   <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      c_read_q    <= c_read_d;
      c_write_q   <= c_write_d;
      c_addr_q    <= c_addr_d;
      c_wdata_q   <= c_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.c_read    = c_read_q;
  assign bus.c_write   = c_write_q;
  assign bus.c_addr    = c_addr_q;
  assign bus.c_wdata   = c_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.count     = fifo_count;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_cache_req_queue.sv
// Directed and randomized bench for cache_req_queue with a behavioural cache and response model.
module tb_cache_req_queue;
  import cache_req_pkg::*;

  localparam int AW = 9;
  localparam int DW = 6;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;
  localparam int RW = DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_req_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  cache_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  req_t          pend_q[$];
  logic [RW-1:0] exp_q[$];
  int            exp_dly_q[$];
  int            issue_cyc_q[$];
  logic          wr_log[$];

  int   cache_lat = 3;   // 0: never strobe, -1: random per request
  bit   fixed_rsp = 1'b0;
  bit   stray_en = 1'b0;
  int   rsp_mode = 1;    // 0: low, 1: high, 2: random
  int   last_len = 0;
  int   rsp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial forever begin
    @(negedge clk);
    if (rsp_mode == 2) bus.rsp_ready = 1'($urandom_range(0, 1));
    else bus.rsp_ready = (rsp_mode == 1);
  end

  // Cache model: takes requests in push order, picks a latency, predicts the response.
  initial begin : cache_model
    int   act_cyc;
    int   lat;
    int   cur_end;
    req_t cur;
    logic [DW-1:0] cur_data;
    logic cur_hit;
    logic active;
    act_cyc = 0;
    lat = 0;
    cur_end = 0;
    cur = '0;
    cur_data = '0;
    cur_hit = 1'b0;
    bus.c_strob = 1'b0;
    bus.c_data = '0;
    bus.c_hit = 1'b0;
    forever begin
      @(negedge clk);
      active = bus.c_read | bus.c_write;
      check("rw_mutex", 32'(bus.c_read & bus.c_write), 0);
      if (!rst) begin
        act_cyc = 0;
        bus.c_strob = 1'b0;
      end else if (active) begin
        if (act_cyc == 0) begin
          check("issue_has_req", 32'(pend_q.size() != 0), 1);
          cur = (pend_q.size() != 0) ? pend_q.pop_front() : '0;
          check("issue_req", {bus.c_write, bus.c_read, bus.c_addr, bus.c_wdata},
                {cur.write, !cur.write, cur.addr, cur.wdata});
          lat = (cache_lat < 0) ? int'($urandom_range(1, TIMEOUT + 2)) : cache_lat;
          cur_data = fixed_rsp ? DW'(6'h2A) : DW'($urandom());
          cur_hit = fixed_rsp ? 1'b1 : 1'($urandom_range(0, 1));
          if (lat != 0 && lat <= TIMEOUT) begin
            cur_end = lat;
            exp_q.push_back({1'b0, cur.write, cur_hit, cur_data});
          end else begin
            cur_end = TIMEOUT;
            exp_q.push_back({1'b1, cur.write, 1'b0, DW'(0)});
          end
          exp_dly_q.push_back(cur_end);
          issue_cyc_q.push_back(cyc_cnt);
        end else begin
          check("issue_stable", {bus.c_write, bus.c_read, bus.c_addr, bus.c_wdata},
                {cur.write, !cur.write, cur.addr, cur.wdata});
          check("issue_len_max", 32'(act_cyc < cur_end), 1);
        end
        act_cyc++;
        bus.c_strob = (lat != 0 && act_cyc == lat);
        bus.c_data = bus.c_strob ? cur_data : DW'($urandom());
        bus.c_hit = bus.c_strob ? cur_hit : 1'($urandom_range(0, 1));
      end else begin
        if (act_cyc != 0) begin
          check("issue_len", act_cyc, cur_end);
          last_len = act_cyc;
          act_cyc = 0;
        end
        bus.c_strob = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.c_data = DW'($urandom());
        bus.c_hit = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: each new response must match the next prediction and then hold.
  initial begin : rsp_monitor
    bit open;
    logic [RW-1:0] held;
    logic [RW-1:0] obs;
    open = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      obs = {bus.rsp_err, bus.rsp_write, bus.rsp_hit, bus.rsp_data};
      if (!rst || !bus.rsp_valid) begin
        open = 1'b0;
      end else if (!open) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("rsp_fields", 32'(obs), 32'(exp_q.pop_front()));
          check("rsp_latency", cyc_cnt - issue_cyc_q.pop_front(), exp_dly_q.pop_front());
        end
        wr_log.push_back(bus.rsp_write);
        rsp_count++;
        held = obs;
        open = 1'b1;
      end else begin
        check("rsp_hold", 32'(obs), 32'(held));
      end
    end
  end

  task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited = 0;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_wait", 32'(waited < 200), 1);
    if (bus.req_ready) begin
      @(posedge clk);
      pend_q.push_back('{write: w, addr: a, wdata: d});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (!(pend_q.size() == 0 && exp_q.size() == 0 && bus.count == 0 &&
             bus.dbg_state == IDLE && !bus.rsp_valid) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(n < bound), 1);
  endtask

  task automatic wait_rsp_valid(input int bound);
    int n = 0;
    while (!bus.rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_rsp_valid", 32'(n < bound), 1);
  endtask

  initial begin : directed
    int n;
    int base;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_fields", {bus.rsp_err, bus.rsp_write, bus.rsp_hit, bus.rsp_data}, 0);
    check("rst_cache_out", {bus.c_read, bus.c_write, bus.c_addr, bus.c_wdata}, 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 1);

    // Single read with a 3-cycle cache.
    fixed_rsp = 1'b1;
    cache_lat = 3;
    base = rsp_count;
    push_req(1'b0, 9'h025, 6'h00);
    drain(100);
    fixed_rsp = 1'b0;
    check("single_c_read_len", last_len, 3);
    check("single_rsp_count", rsp_count - base, 1);

    // Ordering with responses always accepted.
    cache_lat = 2;
    wr_log.delete();
    push_req(1'b1, 9'h010, 6'h15);
    push_req(1'b0, 9'h010, 6'h00);
    push_req(1'b1, 9'h1FF, 6'h3F);
    drain(200);
    check("order_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      check("order_w0", 32'(wr_log[0]), 1);
      check("order_w1", 32'(wr_log[1]), 0);
      check("order_w2", 32'(wr_log[2]), 1);
    end

    // Timeout, then a normal request.
    cache_lat = 0;
    push_req(1'b0, 9'h0AB, 6'h00);
    wait_rsp_valid(TIMEOUT + 10);
    check("tmo_err", 32'(bus.rsp_err), 1);
    check("tmo_data_hit", {bus.rsp_hit, bus.rsp_data}, 0);
    cache_lat = 2;
    push_req(1'b0, 9'h0AC, 6'h00);
    drain(200);

    // Fill with a stalled cache; the fifth waits for the first abort.
    cache_lat = 0;
    for (int i = 0; i < 4; i++) push_req(1'($urandom_range(0, 1)), AW'($urandom()), DW'($urandom()));
    check("fill_count", 32'(bus.count), 4);
    check("fill_ready_low", 32'(bus.req_ready), 0);
    n = 0;
    while (bus.count == 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fill_count_drop", 32'(bus.count), 3);
    check("fill_ready_back", 32'(bus.req_ready), 1);
    push_req(1'b1, 9'h155, 6'h2B);
    drain(400);

    // Backpressure in RESP with stray strobes and a queued request.
    cache_lat = 2;
    rsp_mode = 0;
    push_req(1'b0, 9'h033, 6'h00);
    push_req(1'b1, 9'h044, 6'h11);
    wait_rsp_valid(50);
    stray_en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_no_issue", {bus.c_read, bus.c_write}, 0);
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_count", 32'(bus.count), 1);
    end
    stray_en = 1'b0;
    rsp_mode = 1;
    drain(200);

    // Randomized traffic, latencies and response backpressure.
    cache_lat = -1;
    rsp_mode = 2;
    for (int i = 0; i < 30; i++) begin
      push_req(1'($urandom_range(0, 1)), AW'($urandom()), DW'($urandom()));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(3000);

    // Reset while issuing with three requests buffered.
    cache_lat = 0;
    rsp_mode = 1;
    push_req(1'b0, 9'h101, 6'h00);
    push_req(1'b1, 9'h102, 6'h05);
    push_req(1'b0, 9'h103, 6'h00);
    check("mid_issue", 32'(bus.c_read | bus.c_write), 1);
    check("mid_count", 32'(bus.count), 3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_cache_out", {bus.c_read, bus.c_write}, 0);
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("mrst_req_ready", 32'(bus.req_ready), 0);
    pend_q.delete();
    exp_q.delete();
    exp_dly_q.delete();
    issue_cyc_q.delete();
    @(negedge clk);
    check("mrst_req_ready_hold", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_release_ready", 32'(bus.req_ready), 1);
    cache_lat = 2;
    base = rsp_count;
    push_req(1'b0, 9'h1A0, 6'h00);
    drain(100);
    check("after_rst_rsp_count", rsp_count - base, 1);
    repeat (5) @(negedge clk);
    check("leftover_exp", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
